// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: register map offsets, CTRL field positions and hex glyph table
package seg7_scan_pkg;
    localparam int OFF_CTRL   = 'h00;
    localparam int OFF_BLINK  = 'h04;
    localparam int OFF_MODE   = 'h08;
    localparam int OFF_DP     = 'h0C;
    localparam int OFF_DIGIT  = 'h10;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_BLANK = 1;
    localparam int CTRL_BRI   = 8;
    localparam int BRI_W      = 4;
    // Segment order gfedcba, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg7_scan_controller_if.sv
// seg7_scan_controller_if: single-cycle request / registered-ack register bus
interface seg7_scan_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic                  i_we;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  o_ack;
    logic [DATA_WIDTH-1:0] o_rdata;
    modport master (output i_req, i_we, i_addr, i_wdata, input o_ack, o_rdata);
    modport slave  (input i_req, i_we, i_addr, i_wdata, output o_ack, o_rdata);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex nibble to active-high 7-segment glyph
module seg7_decoder
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    assign o_seg = HEX_GLYPH[i_hex];
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: memory-mapped multiplexed 7-segment scanner with
// per-digit raw/hex mode, decimal points, blink and 16-level PWM brightness
module seg7_scan_controller
    import seg7_scan_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'hc0001000,
    parameter int                    NUM_DIGITS   = 8,
    parameter int                    SCAN_DIV     = 1024,
    parameter int                    BLINK_FRAMES = 64,
    parameter int                    ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_scan_controller_if.slave   bus,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an
);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int FW   = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int STEP = SCAN_DIV / 16;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(OFF_DIGIT + 4 * NUM_DIGITS);

    logic                  w_hit, w_wr, w_lit, w_slot_wrap, w_idx_wrap, w_frame_wrap, w_unused;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [DATA_WIDTH-1:0] w_rd;
    logic [6:0]            w_dec, w_seg;
    logic                  r_en, r_blank, r_phase, r_ack, r_dpo;
    logic [BRI_W-1:0]      r_bright;
    logic [NUM_DIGITS-1:0] r_blink, r_mode, r_dp, r_an;
    logic [6:0]            r_digit [NUM_DIGITS];
    logic [6:0]            r_seg;
    logic [SW-1:0]         r_slot;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_frame;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Word-aligned offset; the low address bits never select anything.
    assign w_off    = (bus.i_addr - BASE_ADDR) & ~ADDR_WIDTH'(3);
    assign w_hit    = (bus.i_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_wr     = bus.i_req && bus.i_we && w_hit;
    assign w_unused = ^bus.i_wdata;

    always_comb begin
        w_rd = '0;
        if (w_off == ADDR_WIDTH'(OFF_CTRL)) begin
            w_rd[CTRL_EN]           = r_en;
            w_rd[CTRL_BLANK]        = r_blank;
            w_rd[CTRL_BRI +: BRI_W] = r_bright;
        end
        if (w_off == ADDR_WIDTH'(OFF_BLINK)) w_rd[NUM_DIGITS-1:0] = r_blink;
        if (w_off == ADDR_WIDTH'(OFF_MODE))  w_rd[NUM_DIGITS-1:0] = r_mode;
        if (w_off == ADDR_WIDTH'(OFF_DP))    w_rd[NUM_DIGITS-1:0] = r_dp;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (w_off == ADDR_WIDTH'(OFF_DIGIT + 4 * i)) w_rd[6:0] = r_digit[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_blank  <= 1'b0;
            r_bright <= '0;
            r_blink  <= '0;
            r_mode   <= '0;
            r_dp     <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
        end else if (w_wr) begin
            if (w_off == ADDR_WIDTH'(OFF_CTRL)) begin
                r_en     <= bus.i_wdata[CTRL_EN];
                r_blank  <= bus.i_wdata[CTRL_BLANK];
                r_bright <= bus.i_wdata[CTRL_BRI +: BRI_W];
            end
            if (w_off == ADDR_WIDTH'(OFF_BLINK)) r_blink <= bus.i_wdata[NUM_DIGITS-1:0];
            if (w_off == ADDR_WIDTH'(OFF_MODE))  r_mode  <= bus.i_wdata[NUM_DIGITS-1:0];
            if (w_off == ADDR_WIDTH'(OFF_DP))    r_dp    <= bus.i_wdata[NUM_DIGITS-1:0];
            for (int i = 0; i < NUM_DIGITS; i++)
                if (w_off == ADDR_WIDTH'(OFF_DIGIT + 4 * i)) r_digit[i] <= bus.i_wdata[6:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= bus.i_req && w_hit;
            r_rdata <= (bus.i_req && w_hit && !bus.i_we) ? w_rd : '0;
        end
    end

    assign bus.o_ack   = r_ack;
    assign bus.o_rdata = r_rdata;

    assign w_slot_wrap  = r_slot == SW'(SCAN_DIV - 1);
    assign w_idx_wrap   = w_slot_wrap && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_frame_wrap = r_frame == FW'(BLINK_FRAMES - 1);

    // Disabling parks the scan so re-enabling always restarts at digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !r_en) begin
            r_slot  <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_phase <= 1'b0;
        end else begin
            r_slot <= w_slot_wrap ? '0 : r_slot + 1'b1;
            if (w_slot_wrap) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            if (w_idx_wrap) begin
                r_frame <= w_frame_wrap ? '0 : r_frame + 1'b1;
                if (w_frame_wrap) r_phase <= ~r_phase;
            end
        end
    end

    seg7_decoder u_dec (
        .i_hex (r_digit[r_idx][3:0]),
        .o_seg (w_dec)
    );

    assign w_seg = r_mode[r_idx] ? r_digit[r_idx] : w_dec;
    assign w_lit = r_en && !r_blank
                && (32'(r_slot) < (32'(r_bright) + 32'd1) * 32'(STEP))
                && !(r_blink[r_idx] && r_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= {7{POL}};
            r_dpo <= POL;
            r_an  <= {NUM_DIGITS{POL}};
        end else begin
            r_seg <= (w_lit ? w_seg : 7'd0) ^ {7{POL}};
            r_dpo <= (w_lit && r_dp[r_idx]) ^ POL;
            r_an  <= (w_lit ? NUM_DIGITS'(1) << r_idx : '0) ^ {NUM_DIGITS{POL}};
        end
    end

    assign o_seg = r_seg;
    assign o_dp  = r_dpo;
    assign o_an  = r_an;
endmodule
